// File: rtl/o_serializer.sv
// LSB-first parallel-to-serial transmitter with a one-word holding register and a zero-gap reload.
// Optional output-enable port OE is enabled by defining O_SERIALIZER_TRISTATE_EN.
module o_serializer #(
    parameter int DATA_WIDTH  = 4,
    parameter     WEAK_KEEPER = "NONE"
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  LOAD,
    output logic                  READY,
    input  logic                  EN,
    output logic                  O,
    output logic                  BUSY,
    output logic                  UNDERRUN
`ifdef O_SERIALIZER_TRISTATE_EN
    ,
    output logic                  OE
`endif
);

    localparam int   CW       = $clog2(DATA_WIDTH);
    localparam logic IDLE_LVL = (WEAK_KEEPER == "PULLUP");
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 3 || DATA_WIDTH > 10) begin : g_bad_width
        $error("o_serializer: DATA_WIDTH=%0d outside legal range 3..10", DATA_WIDTH);
    end
    if (WEAK_KEEPER != "NONE" && WEAK_KEEPER != "PULLUP" && WEAK_KEEPER != "PULLDOWN") begin : g_bad_keeper
        $error("o_serializer: WEAK_KEEPER must be NONE, PULLUP or PULLDOWN");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  o_q, o_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;
    logic                  oe_q, oe_d;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        underrun_d   = 1'b0;

        // A full holding register blocks acceptance, so a load and a drain never collide.
        if (LOAD && !hold_valid_q) begin
            hold_d       = D;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (EN && hold_valid_q) begin
                    state_d      = SHIFT;
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            SHIFT: begin
                if (EN) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
                        if (hold_valid_q) begin
                            shift_d      = hold_q;
                            hold_valid_d = 1'b0;
                        end else begin
                            state_d    = IDLE;
                            shift_d    = '0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with the shifter.
        o_d    = (state_d == SHIFT) ? shift_d[0] : IDLE_LVL;
        busy_d = (state_d == SHIFT);
        oe_d   = (state_d == SHIFT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            o_q          <= IDLE_LVL;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            o_q          <= o_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
            oe_q         <= oe_d;
        end
    end

    assign READY    = !hold_valid_q;
    assign O        = o_q;
    assign BUSY     = busy_q;
    assign UNDERRUN = underrun_q;
`ifdef O_SERIALIZER_TRISTATE_EN
    assign OE       = oe_q;
`else
    logic unused_oe;
    assign unused_oe = oe_q;
`endif

endmodule

// File: tb/tb_o_serializer.sv
// Scoreboard bench for o_serializer: expected bits are queued when a word is accepted and
// popped whenever the serializer advances; directed scenarios check timing and idle levels.
module tb_o_serializer;
    localparam int DW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] D = '0;
    logic          LOAD = 1'b0;
    logic          EN = 1'b1;
    logic          READY, O, BUSY, UNDERRUN;
    logic          READY_pu, O_pu, BUSY_pu, UNDERRUN_pu;
`ifdef O_SERIALIZER_TRISTATE_EN
    logic          OE, OE_pu;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_under  = 0;
    logic sb[$];

    always #5 CLK = ~CLK;

    o_serializer #(.DATA_WIDTH(DW), .WEAK_KEEPER("NONE")) dut (
        .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .READY(READY), .EN(EN),
        .O(O), .BUSY(BUSY), .UNDERRUN(UNDERRUN)
`ifdef O_SERIALIZER_TRISTATE_EN
        , .OE(OE)
`endif
    );

    o_serializer #(.DATA_WIDTH(DW), .WEAK_KEEPER("PULLUP")) dut_pu (
        .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .READY(READY_pu), .EN(EN),
        .O(O_pu), .BUSY(BUSY_pu), .UNDERRUN(UNDERRUN_pu)
`ifdef O_SERIALIZER_TRISTATE_EN
        , .OE(OE_pu)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) sb.push_back(w[i]);
    endtask

    // Presents w at a falling edge, waits for READY, and returns 1ns after the accepting edge.
    task automatic send(input logic [DW-1:0] w);
        int t = 0;
        @(negedge CLK);
        D = w;
        LOAD = 1'b1;
        while (!READY && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (!READY) check("send_timeout", 32'(READY), 32'd1);
        else push_word(w);
        @(posedge CLK);
        #1;
        LOAD = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((sb.size() != 0 || BUSY) && t < 200) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        check({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    // Scoreboard monitor: every enabled edge that leaves the shifter busy emits one new bit.
    initial begin
        logic en_s, rst_s, exp_bit;
        forever begin
            @(posedge CLK);
            en_s  = EN;
            rst_s = RST;
            #1;
            if (UNDERRUN === 1'b1) n_under++;
            if (!rst_s && en_s && BUSY) begin
                if (sb.size() == 0) begin
                    check("sb_extra_bit", 32'd1, 32'd0);
                end else begin
                    exp_bit = sb.pop_front();
                    check("sb_bit", 32'(O), 32'(exp_bit));
                    check("sb_pullup_same", 32'(O_pu), 32'(exp_bit));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bits_a;
        int         under0;
        int         t;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 32'(READY), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_underrun", 32'(UNDERRUN), 32'd0);
        check("rst_o_none", 32'(O), 32'd0);
        check("rst_o_pullup", 32'(O_pu), 32'd1);
`ifdef O_SERIALIZER_TRISTATE_EN
        check("rst_oe", 32'(OE), 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;

        // Single word 4'b1011 with EN=1: bits 1,1,0,1 after edges 2..5, underrun after edge 6
        bits_a = 4'b1011;
        send(4'b1011);
        check("w1_ready_low", 32'(READY), 32'd0);
        check("w1_busy_e1", 32'(BUSY), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            check("w1_busy", 32'(BUSY), 32'd1);
            check("w1_o", 32'(O), 32'(bits_a[i]));
            check("w1_no_underrun", 32'(UNDERRUN), 32'd0);
`ifdef O_SERIALIZER_TRISTATE_EN
            check("w1_oe_on", 32'(OE), 32'd1);
`endif
        end
        @(posedge CLK);
        #1;
        check("w1_busy_end", 32'(BUSY), 32'd0);
        check("w1_underrun", 32'(UNDERRUN), 32'd1);
        check("w1_o_idle", 32'(O), 32'd0);
        check("w1_o_idle_pu", 32'(O_pu), 32'd1);
        check("w1_ready_end", 32'(READY), 32'd1);
`ifdef O_SERIALIZER_TRISTATE_EN
        check("w1_oe_off", 32'(OE), 32'd0);
`endif
        @(posedge CLK);
        #1;
        check("w1_underrun_pulse", 32'(UNDERRUN), 32'd0);

        // Back-to-back words: 8 contiguous busy cycles, underrun only after the last bit
        send(4'b1011);
        @(posedge CLK);
        #1;
        check("b2b_busy_e2", 32'(BUSY), 32'd1);
        send(4'b0110);
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            check("b2b_busy", 32'(BUSY), 32'd1);
            check("b2b_no_underrun", 32'(UNDERRUN), 32'd0);
        end
        @(posedge CLK);
        #1;
        check("b2b_busy_end", 32'(BUSY), 32'd0);
        check("b2b_underrun", 32'(UNDERRUN), 32'd1);
        @(posedge CLK);
        #1;

        // Pause after the 2nd bit: O holds 1 for 3 cycles, then 0,1
        send(4'b1011);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        check("pause_bit1", 32'(O), 32'd1);
        @(negedge CLK);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("pause_hold_o", 32'(O), 32'd1);
            check("pause_busy", 32'(BUSY), 32'd1);
            check("pause_no_underrun", 32'(UNDERRUN), 32'd0);
            if (i < 2) @(negedge CLK);
        end
        @(negedge CLK);
        EN = 1'b1;
        @(posedge CLK);
        #1;
        check("pause_bit2", 32'(O), 32'd0);
        @(posedge CLK);
        #1;
        check("pause_bit3", 32'(O), 32'd1);
        check("pause_busy_last", 32'(BUSY), 32'd1);
        @(posedge CLK);
        #1;
        check("pause_busy_end", 32'(BUSY), 32'd0);
        check("pause_underrun", 32'(UNDERRUN), 32'd1);
        @(posedge CLK);
        #1;

        // LOAD held high over 10 incrementing words: nothing dropped or duplicated
        under0 = n_under;
        @(negedge CLK);
        LOAD = 1'b1;
        for (int w = 0; w < 10; w++) begin
            D = DW'(w + 3);
            t = 0;
            while (!READY && t < 50) begin
                @(negedge CLK);
                t++;
            end
            if (!READY) begin
                check("full_timeout", 32'(READY), 32'd1);
            end else begin
                push_word(D);
                @(negedge CLK);
                check("full_ready_low", 32'(READY), 32'd0);
            end
        end
        LOAD = 1'b0;
        drain("full_drain");
        check("full_one_underrun", 32'(n_under - under0), 32'd1);

        // Random words with random EN stalls
        fork
            begin
                for (int w = 0; w < 12; w++) begin
                    send(DW'($urandom));
                    repeat ($urandom_range(0, 5)) @(posedge CLK);
                end
            end
            begin
                repeat (150) begin
                    @(negedge CLK);
                    EN = ($urandom_range(0, 9) < 7);
                end
            end
        join
        @(negedge CLK);
        EN = 1'b1;
        drain("rand_drain");

        // Reset while shifting the 2nd bit with a second word held
        send(4'b1011);
        @(posedge CLK);
        #1;
        send(4'b0101);
        @(negedge CLK);
        RST = 1'b1;
        sb.delete();
        under0 = n_under;
        @(posedge CLK);
        #1;
        check("mrst_o", 32'(O), 32'd0);
        check("mrst_o_pu", 32'(O_pu), 32'd1);
        check("mrst_ready", 32'(READY), 32'd1);
        check("mrst_busy", 32'(BUSY), 32'd0);
        check("mrst_underrun", 32'(UNDERRUN), 32'd0);
        check("mrst_pu_ready", 32'(READY_pu), 32'd1);
        check("mrst_pu_busy", 32'(BUSY_pu), 32'd0);
        check("mrst_pu_underrun", 32'(UNDERRUN_pu), 32'd0);
`ifdef O_SERIALIZER_TRISTATE_EN
        check("mrst_oe", 32'(OE), 32'd0);
        check("mrst_oe_pu", 32'(OE_pu), 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            check("post_rst_busy", 32'(BUSY), 32'd0);
        end
        check("post_rst_no_underrun", 32'(n_under - under0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
